// File: rtl/pulse_sync_pkg.sv
// Shared types and helpers for the pulse stretch/toggle event crossing source side.
package pulse_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  localparam int unsigned MODE_STRETCH = 0;
  localparam int unsigned MODE_TOGGLE  = 1;

  // Bits needed to count 0 .. value-1; never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((1 << width) < value) begin
      width++;
    end
    return width;
  endfunction

endpackage

// File: rtl/pulse_stretch_ch.sv
// One channel: stretch/toggle FSM plus a saturating pending-event counter.
module pulse_stretch_ch
  import pulse_sync_pkg::*;
#(
  parameter int unsigned MODE   = 0,
  parameter int unsigned HOLD   = 3,
  parameter int unsigned GAP    = 3,
  parameter int unsigned PEND_W = 3
) (
  input  logic              clka,
  input  logic              src_rst,
  input  logic              pulse_i,
  input  logic              ovf_clr_i,
  output logic              sig_o,
  output logic              busy_o,
  output logic              ovf_o,
  output logic [PEND_W-1:0] pend_o
);

  localparam int unsigned CntW = clog2(HOLD + GAP);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP - 1);
  localparam logic [CntW-1:0] WaitLast = CntW'(HOLD + GAP - 1);
  localparam logic [PEND_W-1:0] PendMax = '1;
  localparam bit Toggle = (MODE == MODE_TOGGLE);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              sig_q, sig_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              cnt_zero, ready, start, drop;

  always_comb begin
    cnt_zero = (cnt_q == '0);
    ready    = (state_q == ST_IDLE) ||
               (((state_q == ST_LOW) || (state_q == ST_WAIT)) && cnt_zero);
    start    = ready && (pulse_i || (pend_q != '0));
    drop     = !ready && pulse_i && (pend_q == PendMax);

    state_d = state_q;
    cnt_d   = cnt_zero ? '0 : cnt_q - 1'b1;
    sig_d   = sig_q;

    if (start) begin
      if (Toggle) begin
        state_d = ST_WAIT;
        cnt_d   = WaitLast;
        sig_d   = ~sig_q;
      end else begin
        state_d = ST_HIGH;
        cnt_d   = HoldLast;
        sig_d   = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_HIGH: begin
          if (cnt_zero) begin
            state_d = ST_LOW;
            cnt_d   = GapLast;
            sig_d   = 1'b0;
          end
        end
        ST_LOW, ST_WAIT: begin
          if (cnt_zero) state_d = ST_IDLE;
        end
      endcase
    end

    // A pulse that starts a pending event takes its queue slot, so the count holds.
    pend_d = pend_q;
    if (!ready && pulse_i && !drop) begin
      pend_d = pend_q + 1'b1;
    end else if (start && !pulse_i) begin
      pend_d = pend_q - 1'b1;
    end

    ovf_d  = drop | (ovf_q & ~ovf_clr_i);
    busy_d = (state_d != ST_IDLE) || (pend_d != '0);
  end

  always_ff @(posedge clka) begin
    if (src_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      sig_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      sig_q   <= sig_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign sig_o  = sig_q;
  assign busy_o = busy_q;
  assign ovf_o  = ovf_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/pulse_stretch_queue_mc.sv
// Multi-channel pulse conditioner: independent stretch/toggle channels with event queues.
module pulse_stretch_queue_mc
  import pulse_sync_pkg::*;
#(
  parameter int unsigned CH     = 4,
  parameter int unsigned MODE   = 0,
  parameter int unsigned HOLD   = 3,
  parameter int unsigned GAP    = 3,
  parameter int unsigned PEND_W = 3
) (
  input  logic                 clka,
  input  logic                 src_rst,
  input  logic [CH-1:0]        pulse_in,
  input  logic                 ovf_clr,
  output logic [CH-1:0]        sig_out,
  output logic [CH-1:0]        busy,
  output logic [CH-1:0]        ovf,
  output logic [CH*PEND_W-1:0] pend_cnt
);

  if ((HOLD < 1) || (GAP < 1) || (PEND_W < 1) ||
      ((MODE != MODE_STRETCH) && (MODE != MODE_TOGGLE))) begin : gen_param_err
    $error("pulse_stretch_queue_mc: illegal parameter set");
  end

  for (genvar i = 0; i < int'(CH); i++) begin : gen_ch
    pulse_stretch_ch #(
      .MODE   (MODE),
      .HOLD   (HOLD),
      .GAP    (GAP),
      .PEND_W (PEND_W)
    ) u_ch (
      .clka      (clka),
      .src_rst   (src_rst),
      .pulse_i   (pulse_in[i]),
      .ovf_clr_i (ovf_clr),
      .sig_o     (sig_out[i]),
      .busy_o    (busy[i]),
      .ovf_o     (ovf[i]),
      .pend_o    (pend_cnt[i*PEND_W +: PEND_W])
    );
  end

endmodule

// File: tb/tb_pulse_stretch_queue_mc.sv
// Bench for pulse_stretch_queue_mc: stretch and toggle instances against a timing model.
module tb_pulse_stretch_queue_mc;

  localparam int CH     = 4;
  localparam int HOLD   = 3;
  localparam int GAP    = 3;
  localparam int PEND_W = 3;
  localparam int P      = HOLD + GAP;
  localparam int PMAX   = (1 << PEND_W) - 1;

  logic                 clka = 1'b0;
  logic                 src_rst = 1'b1;
  logic                 ovf_clr = 1'b0;
  logic [CH-1:0]        pulse_in = '0;
  logic [CH-1:0]        sig0, busy0, ovf0, sig1, busy1, ovf1;
  logic [CH*PEND_W-1:0] pend0, pend1;

  always #5 clka = ~clka;

  pulse_stretch_queue_mc #(
    .CH(CH), .MODE(0), .HOLD(HOLD), .GAP(GAP), .PEND_W(PEND_W)
  ) dut_stretch (
    .clka     (clka),
    .src_rst  (src_rst),
    .pulse_in (pulse_in),
    .ovf_clr  (ovf_clr),
    .sig_out  (sig0),
    .busy     (busy0),
    .ovf      (ovf0),
    .pend_cnt (pend0)
  );

  pulse_stretch_queue_mc #(
    .CH(CH), .MODE(1), .HOLD(HOLD), .GAP(GAP), .PEND_W(PEND_W)
  ) dut_toggle (
    .clka     (clka),
    .src_rst  (src_rst),
    .pulse_in (pulse_in),
    .ovf_clr  (ovf_clr),
    .sig_out  (sig1),
    .busy     (busy1),
    .ovf      (ovf1),
    .pend_cnt (pend1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  typedef struct {
    logic [CH-1:0]        sig0;
    logic [CH-1:0]        sig1;
    logic [CH-1:0]        busy;
    logic [CH-1:0]        ovf;
    logic [CH*PEND_W-1:0] pend;
  } exp_t;

  exp_t sb[$];

  // Time-based model: a channel is ready once P cycles have passed since its last start.
  int m_ls[CH];
  int m_pend[CH];
  bit m_ovf[CH];
  bit m_tog[CH];
  int cyc = 0;

  task automatic model_step(input logic [CH-1:0] p, input logic clr, input logic rst);
    exp_t e;
    bit   ready, drop;
    for (int i = 0; i < CH; i++) begin
      if (rst) begin
        m_ls[i]   = -1000;
        m_pend[i] = 0;
        m_ovf[i]  = 1'b0;
        m_tog[i]  = 1'b0;
      end else begin
        ready = (cyc >= m_ls[i] + P);
        drop  = 1'b0;
        if (ready && (p[i] || m_pend[i] > 0)) begin
          m_ls[i]  = cyc;
          m_tog[i] = ~m_tog[i];
          if (!p[i]) m_pend[i]--;
        end else if (!ready && p[i]) begin
          if (m_pend[i] == PMAX) drop = 1'b1;
          else m_pend[i]++;
        end
        m_ovf[i] = drop | (m_ovf[i] & ~clr);
      end
      e.sig0[i] = ((cyc + 1 - m_ls[i]) >= 1) && ((cyc + 1 - m_ls[i]) <= HOLD);
      e.sig1[i] = m_tog[i];
      e.busy[i] = ((cyc + 1) <= (m_ls[i] + P)) || (m_pend[i] != 0);
      e.ovf[i]  = m_ovf[i];
      e.pend[i*PEND_W +: PEND_W] = PEND_W'(m_pend[i]);
    end
    cyc++;
    sb.push_back(e);
  endtask

  task automatic step(input logic [CH-1:0] p, input logic clr, input logic rst);
    exp_t e;
    pulse_in = p;
    ovf_clr  = clr;
    src_rst  = rst;
    model_step(p, clr, rst);
    @(posedge clka);
    #1;
    e = sb.pop_front();
    check_eq("sig_out_stretch", 32'(sig0),  32'(e.sig0));
    check_eq("busy_stretch",    32'(busy0), 32'(e.busy));
    check_eq("ovf_stretch",     32'(ovf0),  32'(e.ovf));
    check_eq("pend_stretch",    32'(pend0), 32'(e.pend));
    check_eq("sig_out_toggle",  32'(sig1),  32'(e.sig1));
    check_eq("busy_toggle",     32'(busy1), 32'(e.busy));
    check_eq("ovf_toggle",      32'(ovf1),  32'(e.ovf));
    check_eq("pend_toggle",     32'(pend1), 32'(e.pend));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [CH-1:0] rp;
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    check_eq("reset_sig", 32'(sig0), 32'd0);
    idle(5);

    // Single pulse on ch0.
    step(4'b0001, 1'b0, 1'b0);
    idle(12);

    // Three back-to-back pulses on ch1 queue behind the first stretch.
    for (int k = 0; k < 3; k++) step(4'b0010, 1'b0, 1'b0);
    idle(25);

    // Ten back-to-back pulses on ch2 saturate the queue; last one is dropped.
    for (int k = 0; k < 10; k++) step(4'b0100, 1'b0, 1'b0);
    idle(30);
    step('0, 1'b1, 1'b0);
    idle(40);

    // Overflow coinciding with ovf_clr keeps ovf set.
    for (int k = 0; k < 10; k++) step(4'b0100, (k == 9), 1'b0);
    idle(65);
    step('0, 1'b1, 1'b0);
    idle(3);

    // Pulses two cycles apart on ch0 (toggle spacing case).
    step(4'b0001, 1'b0, 1'b0);
    idle(1);
    step(4'b0001, 1'b0, 1'b0);
    idle(15);

    // All channels together.
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    idle(16);

    // Reset mid-stretch abandons in-flight and pending work.
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b1);
    idle(15);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < CH; i++) rp[i] = ($urandom_range(0, 2) == 0);
      step(rp, ($urandom_range(0, 15) == 0), ($urandom_range(0, 149) == 0));
    end
    idle(70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
